// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-slot skid pipeline stage with stall, flush and bubble insertion
module pipe_stage_skid #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 69
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    // Encoding doubles as the held-entry count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_head_valid;
    logic                w_head_valid_nxt;
    logic [CTRL_W-1:0]   r_head_ctrl;
    logic [CTRL_W-1:0]   w_head_ctrl_nxt;
    logic [DATA_W-1:0]   r_head_data;
    logic [DATA_W-1:0]   w_head_data_nxt;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [CTRL_W-1:0]   w_skid_ctrl_nxt;
    logic [DATA_W-1:0]   r_skid_data;
    logic [DATA_W-1:0]   w_skid_data_nxt;
    logic                w_in_xfer;
    logic                w_out_xfer;

    // Ready depends only on registered state and stall, so upstream sees no loop through this stage.
    assign in_ready_o  = (r_state != S_TWO) & ~stall_i;
    assign w_in_xfer   = in_valid_i & in_ready_o & ~flush_i;
    assign w_out_xfer  = r_head_valid & out_ready_i & ~stall_i & ~flush_i;

    assign out_valid_o = r_head_valid;
    assign out_ctrl_o  = r_head_ctrl;
    assign out_data_o  = r_head_data;
    assign count_o     = r_state;

    // Next-state and slot contents: flush beats stall beats normal flow; payload is never cleared here.
    always_comb begin
        w_state_nxt      = r_state;
        w_head_valid_nxt = r_head_valid;
        w_head_ctrl_nxt  = r_head_ctrl;
        w_head_data_nxt  = r_head_data;
        w_skid_ctrl_nxt  = r_skid_ctrl;
        w_skid_data_nxt  = r_skid_data;
        if (flush_i) begin
            w_state_nxt      = S_EMPTY;
            w_head_valid_nxt = 1'b0;
            w_head_ctrl_nxt  = '0;
            w_skid_ctrl_nxt  = '0;
        end else if (!stall_i) begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt      = S_ONE;
                        w_head_valid_nxt = 1'b1;
                        w_head_ctrl_nxt  = in_ctrl_i;
                        w_head_data_nxt  = in_data_i;
                    end
                end
                S_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_head_ctrl_nxt = in_ctrl_i;
                        w_head_data_nxt = in_data_i;
                    end else if (w_in_xfer) begin
                        w_state_nxt     = S_TWO;
                        w_skid_ctrl_nxt = in_ctrl_i;
                        w_skid_data_nxt = in_data_i;
                    end else if (w_out_xfer) begin
                        // Head drains: ctrl goes to zero to form a bubble, data keeps its last value.
                        w_state_nxt      = S_EMPTY;
                        w_head_valid_nxt = 1'b0;
                        w_head_ctrl_nxt  = '0;
                    end
                end
                S_TWO: begin
                    // Skid only reaches head through an output transfer; no input is accepted while full.
                    if (w_out_xfer) begin
                        w_state_nxt     = S_ONE;
                        w_head_ctrl_nxt = r_skid_ctrl;
                        w_head_data_nxt = r_skid_data;
                    end
                end
                default: begin
                    w_state_nxt      = S_EMPTY;
                    w_head_valid_nxt = 1'b0;
                    w_head_ctrl_nxt  = '0;
                    w_skid_ctrl_nxt  = '0;
                end
            endcase
        end
    end

    // State and slot registers with synchronous reset that clears every held entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_EMPTY;
            r_head_valid <= 1'b0;
            r_head_ctrl  <= '0;
            r_head_data  <= '0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_head_valid <= w_head_valid_nxt;
            r_head_ctrl  <= w_head_ctrl_nxt;
            r_head_data  <= w_head_data_nxt;
            r_skid_ctrl  <= w_skid_ctrl_nxt;
            r_skid_data  <= w_skid_data_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;
    localparam int CW = 2;
    localparam int DW = 69;
    localparam int EW = CW + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          stall;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    count;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] mq[$];
    logic [DW-1:0] last_data;
    bit            accepted;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_ctrl_i   (in_ctrl),
        .in_data_i   (in_data),
        .stall_i     (stall),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_ctrl_o  (out_ctrl),
        .out_data_o  (out_data),
        .count_o     (count)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs against the model at negedge, advance the model, return at posedge+1.
    task automatic cycle();
        int sz;
        bit in_x;
        bit out_x;
        logic [EW-1:0] popped;
        @(negedge clk);
        sz = mq.size();
        check_val("valid", out_valid, sz > 0);
        check_val("count", count, sz);
        check_val("in_ready", in_ready, (sz < 2) && !stall);
        if (sz > 0) begin
            check_val("head", {out_ctrl, out_data}, mq[0]);
        end else begin
            check_val("bubble_ctrl", out_ctrl, 0);
            check_val("hold_data", out_data, last_data);
        end
        accepted = 1'b0;
        if (rst) begin
            mq.delete();
            last_data = '0;
        end else if (flush) begin
            mq.delete();
        end else if (!stall) begin
            in_x  = in_valid && (sz < 2);
            out_x = (sz > 0) && out_ready;
            if (out_x) begin
                popped = mq.pop_front();
                check_val("pop", {out_ctrl, out_data}, popped);
            end
            if (in_x) begin
                mq.push_back({in_ctrl, in_data});
                accepted = 1'b1;
            end
            if (mq.size() > 0) last_data = mq[0][DW-1:0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        logic [EW-1:0] pend;
        bit            have;
        int            seq;
        rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        last_data = '0;
        rst = 1'b0;
        check_val("rst_count", count, 0);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_ready", in_ready, 1);

        // Streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 2'b11, DW'(i));
            cycle();
            check_val("stream_data", out_data, DW'(i));
            check_val("stream_count", count, 1);
        end
        drive(1'b0, '0, '0);
        cycle();
        cycle();

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 69'h0A); cycle();
        drive(1'b1, 2'b10, 69'h0B); cycle();
        check_val("bp_count", count, 2);
        check_val("bp_ready", in_ready, 0);
        check_val("bp_head", out_data, 69'h0A);
        drive(1'b1, 2'b11, 69'h0C); cycle();
        check_val("bp_c_refused", count, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 6 && !accepted; i++) cycle();
        check_val("bp_c_taken", accepted, 1);
        drive(1'b0, '0, '0);
        repeat (4) cycle();

        // Stall in TWO
        out_ready = 1'b0;
        drive(1'b1, 2'b11, 69'h21); cycle();
        drive(1'b1, 2'b11, 69'h22); cycle();
        stall = 1'b1; out_ready = 1'b1;
        drive(1'b1, 2'b01, 69'h23);
        repeat (3) cycle();
        check_val("stall_count", count, 2);
        check_val("stall_ready", in_ready, 0);
        check_val("stall_head", {out_ctrl, out_data}, {2'b11, 69'h21});
        stall = 1'b0;
        drive(1'b0, '0, '0);
        repeat (3) cycle();

        // Flush in TWO with an incoming entry
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 69'h31); cycle();
        drive(1'b1, 2'b10, 69'h32); cycle();
        flush = 1'b1;
        drive(1'b1, 2'b11, 69'h33); cycle();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check_val("flush_valid", out_valid, 0);
        check_val("flush_ctrl", out_ctrl, 0);
        check_val("flush_count", count, 0);
        check_val("flush_data", out_data, 69'h31);
        cycle();

        // Reset mid-operation in TWO with stall held
        drive(1'b1, 2'b01, 69'h41); cycle();
        drive(1'b1, 2'b01, 69'h42); cycle();
        stall = 1'b1; rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1'b0, '0, '0);
        check_val("mrst_count", count, 0);
        check_val("mrst_valid", out_valid, 0);
        check_val("mrst_ctrl", out_ctrl, 0);
        check_val("mrst_data", out_data, 0);
        check_val("mrst_ready_stalled", in_ready, 0);
        stall = 1'b0;
        #1;
        check_val("mrst_ready", in_ready, 1);
        cycle();

        // Random traffic against the scoreboard
        have = 1'b0;
        seq  = 16'h100;
        for (int i = 0; i < 3000; i++) begin
            if (!have) begin
                pend = {CW'($urandom), DW'(seq)};
                seq++;
                have = 1'b1;
            end
            drive(1'($urandom_range(0, 1)), pend[EW-1:DW], pend[DW-1:0]);
            out_ready = ($urandom_range(0, 9) < 6);
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 99) == 0);
            cycle();
            if (accepted || flush) have = 1'b0;
        end
        drive(1'b0, '0, '0);
        stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) cycle();
        check_val("drained", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
